// File: rtl/ps2_host_if.sv
// Host-side handshake for the PS/2 host: transmit request/byte in, receive
// strobe/byte/error out.
interface ps2_host_if;
  logic       cmd;
  logic [7:0] dat;
  logic       ready;
  logic       hit;
  logic [7:0] kbd;
  logic       err;

  modport master (output cmd, dat, input ready, hit, kbd, err);
  modport slave  (input cmd, dat, output ready, hit, kbd, err);
endinterface

// File: rtl/ps2_host.sv
// PS/2 host controller: receives device frames and sends host-to-device
// command bytes over the open-drain ps_clk/ps_dat pair.
module ps2_host #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int RX_TIMEOUT     = 50000,
  parameter int TX_TIMEOUT     = 375000
) (
  input  logic      clock,
  input  logic      reset_n,
  inout  wire       ps_clk,
  inout  wire       ps_dat,
  ps2_host_if.slave host
);

  typedef enum logic [2:0] {
    IDLE,
    RX,
    TX_INH,
    TX_REQ,
    TX_BITS,
    TX_ACK,
    TX_END
  } state_t;

  localparam logic [18:0] INH_LIMIT = 19'(INHIBIT_CYCLES - 1);
  localparam logic [18:0] TX_LIMIT  = 19'(TX_TIMEOUT - 1);
  localparam logic [15:0] RX_LIMIT  = 16'(RX_TIMEOUT - 1);

  state_t      state;
  state_t      state_next;

  logic        clk_s1;
  logic        clk_s2;
  logic        clk_prev;
  logic        dat_s1;
  logic        dat_s2;
  logic        fall;

  logic [3:0]  bit_cnt;
  logic [7:0]  rx_shift;
  logic        rx_par;
  logic [15:0] rx_cnt;
  logic        rx_ok;

  logic [7:0]  tx_data;
  logic        tx_par;
  logic [18:0] tx_cnt;
  logic        dat_low;
  logic        in_tx;

  logic        ready_q;
  logic        hit_q;
  logic        err_q;
  logic [7:0]  kbd_q;

  logic        hit_set;
  logic        err_set;
  logic        accept;

  // Both lines idle high, so the synchronizers come out of reset at 1 to
  // avoid a spurious falling edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps_dat;
      dat_s2   <= dat_s1;
    end
  end

  assign fall  = !clk_s2 && clk_prev;
  assign in_tx = (state != IDLE) && (state != RX);
  assign rx_ok = (^{rx_shift, rx_par}) && dat_s2;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    hit_set    = 1'b0;
    err_set    = 1'b0;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (host.cmd && ready_q) begin
          accept     = 1'b1;
          state_next = TX_INH;
        end else if (fall && !dat_s2) begin
          state_next = RX;
        end
      end
      RX: begin
        if (fall) begin
          if (bit_cnt == 4'd9) begin
            state_next = IDLE;
            if (rx_ok) begin
              hit_set = 1'b1;
            end else begin
              err_set = 1'b1;
            end
          end
        end else if (rx_cnt == RX_LIMIT) begin
          err_set    = 1'b1;
          state_next = IDLE;
        end
      end
      TX_INH: begin
        if (tx_cnt == INH_LIMIT) begin
          state_next = TX_REQ;
        end
      end
      TX_REQ: begin
        state_next = TX_BITS;
      end
      TX_BITS: begin
        if (fall && bit_cnt == 4'd9) begin
          state_next = TX_ACK;
        end
      end
      TX_ACK: begin
        if (fall) begin
          state_next = TX_END;
          err_set    = dat_s2;
        end
      end
      TX_END: begin
        if (clk_s2 && dat_s2) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // A stalled transmit is abandoned from any TX state.
    if (in_tx && tx_cnt == TX_LIMIT) begin
      state_next = IDLE;
      err_set    = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ready_q  <= 1'b0;
      hit_q    <= 1'b0;
      err_q    <= 1'b0;
      kbd_q    <= 8'h00;
      bit_cnt  <= 4'd0;
      rx_shift <= 8'h00;
      rx_par   <= 1'b0;
      rx_cnt   <= 16'd0;
      tx_data  <= 8'h00;
      tx_par   <= 1'b0;
      tx_cnt   <= 19'd0;
      dat_low  <= 1'b0;
    end else begin
      ready_q <= (state == IDLE) && (state_next == IDLE);
      hit_q   <= hit_set;
      err_q   <= err_set;
      if (hit_set) begin
        kbd_q <= rx_shift;
      end

      if (state_next != state) begin
        bit_cnt <= 4'd0;
      end else if (fall) begin
        bit_cnt <= bit_cnt + 4'd1;
      end

      if (state == RX && fall) begin
        if (bit_cnt < 4'd8) begin
          rx_shift <= {dat_s2, rx_shift[7:1]};
        end else if (bit_cnt == 4'd8) begin
          rx_par <= dat_s2;
        end
      end

      if (state != RX || fall) begin
        rx_cnt <= 16'd0;
      end else begin
        rx_cnt <= rx_cnt + 16'd1;
      end

      if (accept) begin
        tx_data <= host.dat;
        tx_par  <= ~^host.dat;
        tx_cnt  <= 19'd0;
      end else if (in_tx) begin
        tx_cnt <= tx_cnt + 19'd1;
      end

      // Data bits change right after each device falling edge so they are
      // stable when the device samples on the rising edge.
      if (state_next == IDLE) begin
        dat_low <= 1'b0;
      end else if (state == TX_INH && state_next == TX_REQ) begin
        dat_low <= 1'b1;
      end else if (state == TX_BITS && fall) begin
        if (bit_cnt < 4'd8) begin
          dat_low <= ~tx_data[bit_cnt[2:0]];
        end else if (bit_cnt == 4'd8) begin
          dat_low <= ~tx_par;
        end else begin
          dat_low <= 1'b0;
        end
      end
    end
  end

  assign ps_clk = (state == TX_INH) ? 1'b0 : 1'bz;
  assign ps_dat = dat_low ? 1'b0 : 1'bz;

  assign host.ready = ready_q;
  assign host.hit   = hit_q;
  assign host.err   = err_q;
  assign host.kbd   = kbd_q;

endmodule
